// File: rtl/axil_gpio_regs_pkg.sv
// Shared AXI-lite response codes and address-decode helper for the GPIO register bank.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int idx_width(input int addr_width);
        return (addr_width > 2) ? (addr_width - 2) : 1;
    endfunction

endpackage

// File: rtl/axil_gpio_regs_if.sv
// AXI-lite slave bus bundle for the GPIO register bank.
interface axil_gpio_regs_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_gpio_regs_sync2.sv
// Two-flop synchroniser bringing asynchronous status words into the clk domain.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability filter chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/axil_gpio_regs.sv
// AXI-lite register bank: NUM_OUT read/write control words and NUM_IN synchronised status words.
module axil_gpio_regs
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_OUT    = 2,
    parameter int NUM_IN     = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = {DATA_WIDTH{1'b0}}
) (
    input  logic                          clk,
    input  logic                          resetn,
    axil_gpio_regs_if.slave               s_axil,
    output logic [NUM_OUT*DATA_WIDTH-1:0] gpio_out,
    input  logic [((NUM_IN > 0) ? NUM_IN : 1)*DATA_WIDTH-1:0] gpio_in
);
    localparam int IDX_W    = idx_width(ADDR_WIDTH);
    localparam int NB       = DATA_WIDTH / 8;
    localparam int IN_SLOTS = (NUM_IN > 0) ? NUM_IN : 1;

    logic                  aw_held_q, w_held_q, bvalid_q, rvalid_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q, rdata_q;
    logic [NB-1:0]         w_strb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_OUT];
    logic [DATA_WIDTH-1:0] regs_d [NUM_OUT];
    logic [DATA_WIDTH-1:0] in_sync_s [IN_SLOTS];

    logic                  awready_s, wready_s, arready_s;
    logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s, wr_err_s, rd_hit_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s, rd_data_s;
    logic [NB-1:0]         wr_strb_s;
    logic [IDX_W-1:0]      wr_word_s, rd_word_s;
    int                    wr_idx_s, rd_idx_s;

    assign awready_s = ~aw_held_q & ~bvalid_q;
    assign wready_s  = ~w_held_q & ~bvalid_q;
    assign arready_s = ~rvalid_q;
    assign aw_hs_s   = s_axil.awvalid & awready_s;
    assign w_hs_s    = s_axil.wvalid & wready_s;
    assign ar_hs_s   = s_axil.arvalid & arready_s;
    // Commit once both halves are present, whether held from earlier or arriving now.
    assign commit_s  = (aw_held_q | aw_hs_s) & (w_held_q | w_hs_s) & ~bvalid_q;

    assign wr_addr_s = aw_held_q ? aw_addr_q : s_axil.awaddr;
    assign wr_data_s = w_held_q ? w_data_q : s_axil.wdata;
    assign wr_strb_s = w_held_q ? w_strb_q : s_axil.wstrb;
    assign wr_word_s = wr_addr_s[ADDR_WIDTH-1:2];
    assign rd_word_s = s_axil.araddr[ADDR_WIDTH-1:2];
    assign wr_idx_s  = 32'(wr_word_s);
    assign rd_idx_s  = 32'(rd_word_s);
    assign wr_err_s  = (wr_idx_s >= NUM_OUT);

    assign s_axil.awready = awready_s;
    assign s_axil.wready  = wready_s;
    assign s_axil.arready = arready_s;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rresp   = rresp_q;
    assign s_axil.rdata   = rdata_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
            assign gpio_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
        end
        if (NUM_IN > 0) begin : g_in
            for (gi = 0; gi < NUM_IN; gi++) begin : g_sync
                sync2 #(.WIDTH(DATA_WIDTH)) u_sync2 (
                    .clk   (clk),
                    .rst_n (resetn),
                    .d_i   (gpio_in[gi*DATA_WIDTH +: DATA_WIDTH]),
                    .q_o   (in_sync_s[gi])
                );
            end
        end else begin : g_no_in
            assign in_sync_s[0] = {DATA_WIDTH{1'b0}};
        end
    endgenerate

    // Byte-lane merge of the committing write into the addressed output register.
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            regs_d[i] = regs_q[i];
            for (int b = 0; b < NB; b++) begin
                regs_d[i][8*b +: 8] = (commit_s && (wr_idx_s == i) && wr_strb_s[b]) ?
                                      wr_data_s[8*b +: 8] : regs_q[i][8*b +: 8];
            end
        end
    end

    // Read decode as a one-hot OR mux; no hit means unmapped.
    always_comb begin
        rd_data_s = {DATA_WIDTH{1'b0}};
        rd_hit_s  = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            rd_data_s = rd_data_s | ({DATA_WIDTH{rd_idx_s == i}} & regs_q[i]);
            rd_hit_s  = rd_hit_s | (rd_idx_s == i);
        end
        for (int i = 0; i < NUM_IN; i++) begin
            rd_data_s = rd_data_s | ({DATA_WIDTH{rd_idx_s == (NUM_OUT + i)}} & in_sync_s[i]);
            rd_hit_s  = rd_hit_s | (rd_idx_s == (NUM_OUT + i));
        end
    end

    // Write channel: hold flags, response and register state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= {ADDR_WIDTH{1'b0}};
            w_data_q  <= {DATA_WIDTH{1'b0}};
            w_strb_q  <= {NB{1'b0}};
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            for (int i = 0; i < NUM_OUT; i++) regs_q[i] <= RESET_VAL;
        end else begin
            aw_held_q <= ~commit_s & (aw_held_q | aw_hs_s);
            w_held_q  <= ~commit_s & (w_held_q | w_hs_s);
            if (aw_hs_s) aw_addr_q <= s_axil.awaddr;
            else         aw_addr_q <= aw_addr_q;
            if (w_hs_s) begin
                w_data_q <= s_axil.wdata;
                w_strb_q <= s_axil.wstrb;
            end else begin
                w_data_q <= w_data_q;
                w_strb_q <= w_strb_q;
            end
            if (commit_s) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && s_axil.bready) begin
                bvalid_q <= 1'b0;
            end else begin
                bvalid_q <= bvalid_q;
            end
            for (int i = 0; i < NUM_OUT; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Read channel: single outstanding response, data captured at the AR handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= {DATA_WIDTH{1'b0}};
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs_s) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_s;
            rresp_q  <= rd_hit_s ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_axil.rready) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_q;
        end
    end
endmodule

// File: tb/tb_axil_gpio_regs.sv
// Directed bench for axil_gpio_regs with hand-computed expectations.
module tb_axil_gpio_regs;
    logic        clk;
    logic        resetn;
    logic [63:0] gpio_out;
    logic [31:0] gpio_in;
    int          errors;
    int          checks;

    axil_gpio_regs_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    axil_gpio_regs #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (4),
        .NUM_OUT    (2),
        .NUM_IN     (1),
        .RESET_VAL  (32'hA5A5_0000)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .s_axil   (bus.slave),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        resetn = 1'b0;
        gpio_in = 32'h0;
        bus.awaddr = 4'h0; bus.awvalid = 1'b0;
        bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = 4'h0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_gpio_out", gpio_out, 64'hA5A50000_A5A50000);
        chk("rst_bvalid", {63'd0, bus.bvalid}, 64'd0);
        chk("rst_rvalid", {63'd0, bus.rvalid}, 64'd0);
        chk("rst_bresp", {62'd0, bus.bresp}, 64'd0);
        chk("rst_rresp", {62'd0, bus.rresp}, 64'd0);
        chk("rst_rdata", {32'd0, bus.rdata}, 64'd0);
        resetn = 1'b1;
        tick();
        chk("rel_readies", {61'd0, bus.awready, bus.wready, bus.arready}, 64'd7);

        // Simultaneous AW+W to reg1
        bus.awaddr = 4'h4; bus.awvalid = 1'b1;
        bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("sim_bvalid", {63'd0, bus.bvalid}, 64'd1);
        chk("sim_bresp", {62'd0, bus.bresp}, 64'd0);
        chk("sim_gpio_hi", {32'd0, gpio_out[63:32]}, 64'hDEADBEEF);
        chk("sim_no_accept", {62'd0, bus.awready, bus.wready}, 64'd0);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("sim_bvalid_clr", {63'd0, bus.bvalid}, 64'd0);
        bus.araddr = 4'h4; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("rd1_rvalid", {63'd0, bus.rvalid}, 64'd1);
        chk("rd1_rdata", {32'd0, bus.rdata}, 64'hDEADBEEF);
        chk("rd1_arready", {63'd0, bus.arready}, 64'd0);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        chk("rd1_rvalid_clr", {63'd0, bus.rvalid}, 64'd0);

        // W three cycles ahead of AW, partial strobes to reg0
        bus.wdata = 32'h11223344; bus.wstrb = 4'h5; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        chk("dec_wready", {63'd0, bus.wready}, 64'd0);
        chk("dec_awready", {63'd0, bus.awready}, 64'd1);
        chk("dec_no_b", {63'd0, bus.bvalid}, 64'd0);
        tick(); tick();
        chk("dec_reg0_pre", {32'd0, gpio_out[31:0]}, 64'hA5A50000);
        bus.awaddr = 4'h0; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        chk("dec_bvalid", {63'd0, bus.bvalid}, 64'd1);
        chk("dec_reg0", {32'd0, gpio_out[31:0]}, 64'hA5220044);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("dec_hold_b", {61'd0, bus.bvalid, bus.bresp}, 64'h4);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("dec_bvalid_clr", {63'd0, bus.bvalid}, 64'd0);

        // Synchronised input read
        gpio_in = 32'h0000CAFE;
        tick(); tick();
        bus.araddr = 4'h8; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("in_rdata", {32'd0, bus.rdata}, 64'h0000CAFE);
        chk("in_rresp", {62'd0, bus.rresp}, 64'd0);
        bus.rready = 1'b1; tick(); bus.rready = 1'b0;

        // Write to the read-only word
        bus.awaddr = 4'h8; bus.awvalid = 1'b1;
        bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("ro_bresp", {61'd0, bus.bvalid, bus.bresp}, 64'h6);
        chk("ro_unchanged", gpio_out, 64'hDEADBEEF_A5220044);
        bus.bready = 1'b1; tick(); bus.bready = 1'b0;

        // Unmapped read
        bus.araddr = 4'hC; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("unm_rdata", {32'd0, bus.rdata}, 64'd0);
        chk("unm_rresp", {62'd0, bus.rresp}, 64'h2);
        bus.rready = 1'b1; tick(); bus.rready = 1'b0;

        // Low address bits ignored
        bus.araddr = 4'h7; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("lowbits_rdata", {32'd0, bus.rdata}, 64'hDEADBEEF);
        bus.rready = 1'b1; tick(); bus.rready = 1'b0;

        // Zero strobe to a valid register
        bus.awaddr = 4'h4; bus.awvalid = 1'b1;
        bus.wdata = 32'h0BADF00D; bus.wstrb = 4'h0; bus.wvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("zstrb_bresp", {61'd0, bus.bvalid, bus.bresp}, 64'h4);
        chk("zstrb_gpio", gpio_out, 64'hDEADBEEF_A5220044);
        bus.bready = 1'b1; tick(); bus.bready = 1'b0;

        // Read and commit to reg0 on the same edge
        bus.awaddr = 4'h0; bus.awvalid = 1'b1;
        bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 4'h0; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        chk("coll_rdata_old", {32'd0, bus.rdata}, 64'hA5220044);
        chk("coll_gpio_new", {32'd0, gpio_out[31:0]}, 64'h12345678);
        chk("coll_bvalid", {63'd0, bus.bvalid}, 64'd1);

        // Reset mid-response
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_bvalid", {62'd0, bus.bvalid, bus.rvalid}, 64'd0);
        chk("mid_rst_gpio", gpio_out, 64'hA5A50000_A5A50000);
        tick();
        resetn = 1'b1;
        tick();
        chk("post_rst_readies", {61'd0, bus.awready, bus.wready, bus.arready}, 64'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
